shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_seq_pkg.sv | 6 +
 rtl/shift_seq_slot.sv | 34 +++
 rtl/shift_sequencer.sv | 79 +++++++
 tb/tb_shift_sequencer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared FSM state type and default widths for the shift sequencer
package shift_seq_pkg;
  localparam int SEQ_DATA_W = 8;
  localparam int SEQ_CNT_W  = 3;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} seq_state_e;
endpackage

// File: rtl/shift_seq_slot.sv
// shift_seq_slot: one-entry pending request buffer (used only with SHIFT_SEQ_QUEUE_EN)
//   i_push/i_pop: capture / release the entry; i_val/i_amt/i_arith: request in
//   o_full: entry valid; o_val/o_amt/o_arith: buffered request out
module shift_seq_slot import shift_seq_pkg::*; #(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int CNT_W  = SEQ_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_val,
  input  logic [CNT_W-1:0]  i_amt,
  input  logic              i_arith,
  output logic              o_full,
  output logic [DATA_W-1:0] o_val,
  output logic [CNT_W-1:0]  o_amt,
  output logic              o_arith
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      o_full  <= 1'b0;
      o_val   <= '0;
      o_amt   <= '0;
      o_arith <= 1'b0;
    end else if (i_push) begin
      o_full  <= 1'b1;
      o_val   <= i_val;
      o_amt   <= i_amt;
      o_arith <= i_arith;
    end else if (i_pop) begin
      o_full  <= 1'b0;
    end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences load/shift strobes for an external right shifter
//   start/req_val/req_amt/req_arith: request, accepted when ready
//   ready/busy/done: handshake and status; load_n/shift_right/asr/load_val: shifter controls
//   remaining: shifts still to issue
//   SHIFT_SEQ_QUEUE_EN: adds a one-entry pending request buffer
module shift_sequencer import shift_seq_pkg::*; #(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int CNT_W  = SEQ_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] req_val,
  input  logic [CNT_W-1:0]  req_amt,
  input  logic              req_arith,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              load_n,
  output logic              shift_right,
  output logic              asr,
  output logic [DATA_W-1:0] load_val,
  output logic [CNT_W-1:0]  remaining
);
  seq_state_e        r_state, w_next;
  logic [DATA_W-1:0] r_val, w_val;
  logic [CNT_W-1:0]  r_rem, w_amt;
  logic              r_arith, w_arith, w_take;
`ifdef SHIFT_SEQ_QUEUE_EN
  logic              w_full, w_pop, w_sarith;
  logic [DATA_W-1:0] w_sval;
  logic [CNT_W-1:0]  w_samt;
  // a buffered request launches straight from DONE (or IDLE if it was captured in DONE)
  assign w_pop   = w_full & (r_state == S_DONE || r_state == S_IDLE);
  assign ready   = ~w_full;
  assign w_take  = w_pop | (r_state == S_IDLE & start);
  assign w_val   = w_pop ? w_sval : req_val;
  assign w_amt   = w_pop ? w_samt : req_amt;
  assign w_arith = w_pop ? w_sarith : req_arith;
  shift_seq_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot (
    .clk(clk), .reset_n(reset_n), .i_push(start & busy & ~w_full), .i_pop(w_pop),
    .i_val(req_val), .i_amt(req_amt), .i_arith(req_arith),
    .o_full(w_full), .o_val(w_sval), .o_amt(w_samt), .o_arith(w_sarith)
  );
`else
  assign ready   = ~busy;
  assign w_take  = start & (r_state == S_IDLE);
  assign w_val   = req_val;
  assign w_amt   = req_amt;
  assign w_arith = req_arith;
`endif
  assign busy        = r_state != S_IDLE;
  assign done        = r_state == S_DONE;
  assign load_n      = r_state != S_LOAD;
  assign shift_right = r_state == S_SHIFT;
  assign asr         = r_arith & (r_state == S_LOAD || r_state == S_SHIFT);
  assign load_val    = r_val;
  assign remaining   = r_rem;
  always_comb
    w_next = r_state == S_LOAD  ? (r_rem != '0 ? S_SHIFT : S_DONE) :
             r_state == S_SHIFT ? (r_rem == CNT_W'(1) ? S_DONE : S_SHIFT) :
             w_take ? S_LOAD : S_IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_val   <= '0;
      r_rem   <= '0;
      r_arith <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_val   <= w_val;
        r_rem   <= w_amt;
        r_arith <= w_arith;
      end else if (r_state == S_SHIFT) begin
        r_rem   <= r_rem - 1'b1;
      end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven and randomized checks of shift_sequencer (default build)
module tb_shift_sequencer;
  logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, req_arith = 1'b0;
  logic [7:0] req_val = '0;
  logic [2:0] req_amt = '0;
  logic       ready, busy, done, load_n, shift_right, asr;
  logic [7:0] load_val, sh;
  logic [2:0] remaining;
  int         total = 0, bad = 0, ndone = 0;

  typedef struct {logic [7:0] v; logic [2:0] a; logic ar; logic [7:0] e;} vec_t;
  vec_t tbl[6];

  shift_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .req_val(req_val), .req_amt(req_amt),
    .req_arith(req_arith), .ready(ready), .busy(busy), .done(done), .load_n(load_n),
    .shift_right(shift_right), .asr(asr), .load_val(load_val), .remaining(remaining)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!load_n) sh <= load_val;
    else if (shift_right) sh <= asr ? {sh[7], sh[7:1]} : {1'b0, sh[7:1]};

  always @(negedge clk) if (done) ndone++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] v, input logic [2:0] a, input logic ar);
    logic signed [7:0] s;
    s = v;
    return ar ? 8'(s >>> a) : 8'(v >> a);
  endfunction

  task automatic chk_reset_vals();
    chk("rst_ready", ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_load_n", load_n, 1); chk("rst_shr", shift_right, 0); chk("rst_asr", asr, 0);
    chk("rst_load_val", load_val, 0); chk("rst_rem", remaining, 0);
  endtask

  task automatic run(input logic [7:0] v, input logic [2:0] a, input logic ar, input logic [7:0] e, input bit noise);
    int nd;
    @(negedge clk);
    chk("ready_idle", ready, 1); chk("busy_idle", busy, 0);
    start = 1; req_val = v; req_amt = a; req_arith = ar;
    @(negedge clk);
    nd = ndone;
    chk("load_n", load_n, 0); chk("shr_in_load", shift_right, 0); chk("rem_load", remaining, a);
    chk("asr_load", asr, ar); chk("load_val", load_val, v); chk("busy", busy, 1); chk("ready_busy", ready, 0);
    start = noise;
    if (noise) begin req_val = 8'($urandom); req_amt = 3'($urandom); req_arith = 1'($urandom); end
    for (int k = 0; k < a; k++) begin
      @(negedge clk);
      chk("shr", shift_right, 1); chk("load_n_shift", load_n, 1);
      chk("rem_shift", remaining, a - k); chk("asr_shift", asr, ar); chk("done_early", done, 0);
      if (noise) req_val = 8'($urandom);
    end
    @(negedge clk);
    start = 0;
    chk("done", done, 1); chk("rem_done", remaining, 0); chk("shr_done", shift_right, 0);
    chk("result", sh, e); chk("load_val_hold", load_val, v);
    @(negedge clk);
    chk("done_pulse", done, 0); chk("busy_end", busy, 0); chk("done_count", ndone - nd, 1);
  endtask

  initial begin
    int nd;
    logic [7:0] v;
    logic [2:0] a;
    logic ar;
    tbl[0] = '{8'h96, 3'd3, 1'b1, 8'hF2};
    tbl[1] = '{8'h96, 3'd3, 1'b0, 8'h12};
    tbl[2] = '{8'h5A, 3'd0, 1'b0, 8'h5A};
    tbl[3] = '{8'h80, 3'd7, 1'b1, 8'hFF};
    tbl[4] = '{8'h80, 3'd7, 1'b0, 8'h01};
    tbl[5] = '{8'h7F, 3'd7, 1'b1, 8'h00};
    #1 chk_reset_vals();
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 6; i++) run(tbl[i].v, tbl[i].a, tbl[i].ar, tbl[i].e, 1'b0);
    run(8'hA5, 3'd7, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom); a = 3'($urandom); ar = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run(v, a, ar, ref_shift(v, a, ar), 1'($urandom));
    end
    @(negedge clk);
    start = 1; req_val = 8'hC3; req_amt = 3'd5; req_arith = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    chk("pre_rst_shr", shift_right, 1);
    nd = ndone;
    #2 reset_n = 0;
    #1 chk_reset_vals();
    repeat (2) @(negedge clk);
    chk("rst_no_done", ndone - nd, 0);
    start = 1; req_val = 8'h3C; req_amt = 3'd0; req_arith = 0; reset_n = 1;
    @(negedge clk);
    start = 0;
    chk("first_accept_load_n", load_n, 0); chk("first_accept_val", load_val, 8'h3C);
    @(negedge clk);
    chk("post_rst_done", done, 1); chk("post_rst_result", sh, 8'h3C);
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  always @(negedge clk) if (!load_n && shift_right) begin
    bad++;
    $display("FAIL load_shift_overlap: got 1 want 0");
  end
endmodule
